d_mem_wait_sram: RTL and testbench
==================================

# d_mem_wait_sram

Parametrised data-memory responder for the core's `d_mem_*` port. It is a synthesizable, wait-stated generalisation of the simple bench data bank, with these features:
- configurable data width, depth and byte-lane count;
- a runtime-programmable wait-state count;
- a self-initialising sweep after reset;
- out-of-range error reporting.

It sits between the core's data port and either a simulation top or an FPGA block RAM.

## Interface
- `DATA_W`, 16: word width; multiple of 8, at least 16. `LANES = DATA_W/8`.
- `ADDR_W`, 16: byte-address width.
- `DEPTH_WORDS`, 32768: number of words implemented. Byte range is `DEPTH_WORDS*LANES`.
- `WAIT_W`, 4: width of `cfg_wait`.
- `INIT_MODE`, 1: reset fill pattern.
  - 0: all bytes 0.
  - 1: byte at address a = a[15:8] (bits 8 and up, truncated to 8).

- `clk` in 1: single clock, rising edge.
- `a_rst` in 1: reset, synchronous, active-low.
- `d_mem_assert` in 1: request valid.
- `d_mem_cmd` in 1: 1 = write, 0 = read.
- `d_mem_addr` in ADDR_W: byte address.
- `d_mem_be` in LANES: byte enables. All ones = word access; any other value = byte access.
- `d_mem_data_out` in DATA_W: write data from the core.
- `d_mem_data_in` out DATA_W: read data to the core.
- `d_mem_rdy` out 1: responder can accept a request / current request complete.
- `d_mem_err` out 1: completed request was out of range.
- `cfg_wait` in WAIT_W: wait states, sampled at accept.
- `init_busy` out 1: reset fill in progress.

## Operation
- **States:** INIT, IDLE, BUSY, DONE.
- **Lane mapping (big-endian):**
  - word index w = addr >> log2(LANES); offset k = addr[log2(LANES)-1:0].
  - byte k occupies bits [DATA_W-1-8k -: 8].
- **Word access:** offset bits are ignored (access is aligned).
  - Read returns the full word.
  - Write stores all of `d_mem_data_out`.
- **Byte access:**
  - Read returns the byte at addr zero-extended into [7:0]; upper bits are 0.
  - Write stores `d_mem_data_out[7:0]` into byte k only.
- **Range:** request is out of range if w >= DEPTH_WORDS.
  - Out-of-range read returns 0.
  - Out-of-range write is dropped.
  - `d_mem_err` = 1 in DONE. `d_mem_err` is 0 in DONE for in-range requests.
- **INIT:** one word written per cycle, w = 0 .. DEPTH_WORDS-1, with the INIT_MODE pattern.
  - `init_busy` = 1 and `d_mem_rdy` = 0 throughout.
  - Requests presented during INIT are ignored, not queued.
  - After the last word, go to IDLE.
- **IDLE:** `d_mem_rdy` = 1.
  - On an edge with `d_mem_assert` = 1: capture cmd/addr/be/data and cnt = `cfg_wait`, then go to BUSY.
- **BUSY:** `d_mem_rdy` = 0.
  - If cnt == 0: perform the access, register the read data / err, go to DONE.
  - Else: cnt--.
- **DONE:** `d_mem_rdy` = 1; `d_mem_data_in` is valid for a read.
  - If `d_mem_assert` = 1 on the edge: accept a new request and go to BUSY (back-to-back).
  - Else: go to IDLE.
- **Inputs while BUSY:** ignored; captured values are used.
- **`d_mem_data_in` hold:** keeps the last completed read value until the next read completes. A write completion does not change it.
- **Reset:** `a_rst` = 0 on any edge, including mid-BUSY or mid-INIT:
  - any in-flight access is abandoned; a write not yet performed is dropped;
  - state goes to INIT with w = 0.
  - While `a_rst` = 0: `d_mem_rdy` = 0, `d_mem_err` = 0, `d_mem_data_in` = 0, `init_busy` = 1.

## Timing
- **Reset values:** `d_mem_rdy` = 0, `d_mem_err` = 0, `d_mem_data_in` = 0, `init_busy` = 1.
- **Init length:** the first edge with `a_rst` = 1 writes word 0. Init lasts exactly DEPTH_WORDS cycles. `d_mem_rdy` rises in the cycle after the edge that writes the last word.
- **Latency:** accept on edge E0 → access on edge E0+`cfg_wait`+1. `d_mem_rdy` = 1 with data valid in the cycle following that edge.
- **Throughput:**
  - back-to-back accept from DONE: one request per `cfg_wait`+2 cycles, with the rdy-high DONE cycle doubling as the accept cycle;
  - via IDLE: one request per `cfg_wait`+3 cycles.
- **Maximum wait:** `cfg_wait` = 2^WAIT_W−1 gives 2^WAIT_W BUSY cycles.
- **Registering:** all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Init + word read** (defaults): wait for `init_busy` = 0 (32768 cycles after reset release); read word 0xC000 with `cfg_wait` = 0 → `d_mem_data_in` = 0xC0C0, `d_mem_err` = 0, rdy high 2 cycles after accept.
- **Byte read / write:**
  - Byte read at 0xB001 → 0x00B0.
  - Byte write 0x1234 to 0x00A3, then word read at 0x00A2 → 0x0034.
  - Byte write 0x5678 to 0x00A2, then word read at 0x00A2 → 0x7834.
- **Wait states:** `cfg_wait` = 3, word write 0xC000 to 0x00A0 accepted at E0 → rdy low for E0+1..E0+4, high after E0+4. Following read of 0x00A0 → 0xC000.
- **Out-of-range:** with DEPTH_WORDS = 64, INIT_MODE = 0:
  - read at 0x0080 → `d_mem_err` = 1, data 0;
  - write 0xFFFF to 0x0080, then read 0x0000 → 0x0000;
  - read 0x007E → err = 0.
- **Back-to-back:** `d_mem_assert` held high for 3 reads (0x0010, 0x0012, 0x0014) with `cfg_wait` = 1 → DONE every 3 cycles, correct data each, no IDLE cycle between.
- **Reset mid-operation:** pull `a_rst` low during BUSY of a write 0xBEEF to 0x0020 → write dropped; after re-init, read 0x0020 → init pattern (0x0000); `init_busy` reasserted.

Source files
------------

// File: rtl/d_mem_wait_sram.sv
// Wait-stated data-memory responder for the core's d_mem_* port, with a
// self-initialising fill after reset and out-of-range error reporting.
module d_mem_wait_sram #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 32768,
  parameter int WAIT_W      = 4,
  parameter int INIT_MODE   = 1
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              d_mem_assert,
  input  logic              d_mem_cmd,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W/8-1:0] d_mem_be,
  input  logic [DATA_W-1:0] d_mem_data_out,
  output logic [DATA_W-1:0] d_mem_data_in,
  output logic              d_mem_rdy,
  output logic              d_mem_err,
  input  logic [WAIT_W-1:0] cfg_wait,
  output logic              init_busy
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_DONE} state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0]  init_idx;
  logic [WAIT_W-1:0] cnt;

  logic              cap_cmd;
  logic [ADDR_W-1:0] cap_addr;
  logic [LANES-1:0]  cap_be;
  logic [DATA_W-1:0] cap_data;

  logic [ADDR_W-1:0] cap_word;
  logic [OFF_W-1:0]  cap_off;
  logic [IDX_W-1:0]  cap_idx;
  logic              in_range;
  logic              word_acc;
  logic              accept;
  logic              access;

  logic              mem_we;
  logic [LANES-1:0]  lane_we;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_val;

  // Big-endian lanes: byte k of a word lives at bits [DATA_W-1-8k -: 8].
  function automatic logic [DATA_W-1:0] lane_extract(input logic [DATA_W-1:0] w,
                                                      input logic [OFF_W-1:0]  k);
    logic [DATA_W-1:0] r;
    r      = '0;
    r[7:0] = w[DATA_W-1-8*int'(k) -: 8];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] init_word(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] r;
    r = '0;
    if (INIT_MODE == 1) begin
      for (int k = 0; k < LANES; k++) begin
        r[DATA_W-1-8*k -: 8] = 8'((32'(idx) * LANES + k) >> 8);
      end
    end
    return r;
  endfunction

  assign cap_word = cap_addr >> OFF_W;
  assign cap_off  = cap_addr[OFF_W-1:0];
  assign cap_idx  = cap_word[IDX_W-1:0];
  assign in_range = 32'(cap_word) < 32'(DEPTH_WORDS);
  assign word_acc = (cap_be == {LANES{1'b1}});
  assign accept   = a_rst && d_mem_assert && (state == S_IDLE || state == S_DONE);
  assign access   = a_rst && (state == S_BUSY) && (cnt == '0);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!a_rst) state <= S_INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT: if (init_idx == IDX_W'(DEPTH_WORDS - 1)) state_nx = S_IDLE;
      S_IDLE: if (d_mem_assert) state_nx = S_BUSY;
      S_BUSY: if (cnt == '0) state_nx = S_DONE;
      S_DONE: state_nx = d_mem_assert ? S_BUSY : S_IDLE;
      default: state_nx = S_INIT;
    endcase
  end

  always_comb begin
    d_mem_rdy = (state == S_IDLE) || (state == S_DONE);
    init_busy = (state == S_INIT);
  end

  // Control registers: fill pointer, wait counter, response outputs
  always_ff @(posedge clk) begin
    if (!a_rst) begin
      init_idx      <= '0;
      cnt           <= '0;
      d_mem_err     <= 1'b0;
      d_mem_data_in <= '0;
    end else begin
      if (state == S_INIT) init_idx <= init_idx + IDX_W'(1);
      if (accept) cnt <= cfg_wait;
      else if (state == S_BUSY && cnt != '0) cnt <= cnt - WAIT_W'(1);
      if (access) begin
        d_mem_err <= !in_range;
        if (!cap_cmd) d_mem_data_in <= in_range ? rd_val : '0;
      end
    end
  end

  // Request capture; held stable for the whole BUSY period
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_cmd  <= d_mem_cmd;
      cap_addr <= d_mem_addr;
      cap_be   <= d_mem_be;
      cap_data <= d_mem_data_out;
    end
  end

  assign rd_word = mem[cap_idx];
  assign rd_val  = word_acc ? rd_word : lane_extract(rd_word, cap_off);

  // Single write port shared by the init sweep and core writes; gated by reset
  always_comb begin
    mem_we  = 1'b0;
    lane_we = '0;
    wr_idx  = init_idx;
    wr_data = init_word(init_idx);
    if (a_rst && state == S_INIT) begin
      mem_we  = 1'b1;
      lane_we = '1;
    end else if (access && cap_cmd && in_range) begin
      mem_we = 1'b1;
      wr_idx = cap_idx;
      if (word_acc) begin
        lane_we = '1;
        wr_data = cap_data;
      end else begin
        lane_we[cap_off] = 1'b1;
        wr_data          = {LANES{cap_data[7:0]}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_we[l]) mem[wr_idx][DATA_W-1-8*l -: 8] <= wr_data[DATA_W-1-8*l -: 8];
      end
    end
  end

endmodule

// File: tb/tb_d_mem_wait_sram.sv
// Directed bench for d_mem_wait_sram: a default instance plus a 64-word,
// zero-filled instance sharing the same request bus.
module tb_d_mem_wait_sram;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        d_mem_assert;
  logic        d_mem_cmd;
  logic [15:0] d_mem_addr;
  logic [1:0]  d_mem_be;
  logic [15:0] d_mem_data_out;
  logic [3:0]  cfg_wait;

  logic [15:0] d_mem_data_in;
  logic        d_mem_rdy;
  logic        d_mem_err;
  logic        init_busy;

  logic [15:0] s_data_in;
  logic        s_rdy;
  logic        s_err;
  logic        s_init_busy;

  int compared   = 0;
  int mismatched = 0;
  int lat;

  always #5 clk = ~clk;

  d_mem_wait_sram dut (
    .clk(clk), .a_rst(a_rst), .d_mem_assert(d_mem_assert), .d_mem_cmd(d_mem_cmd),
    .d_mem_addr(d_mem_addr), .d_mem_be(d_mem_be), .d_mem_data_out(d_mem_data_out),
    .d_mem_data_in(d_mem_data_in), .d_mem_rdy(d_mem_rdy), .d_mem_err(d_mem_err),
    .cfg_wait(cfg_wait), .init_busy(init_busy)
  );

  d_mem_wait_sram #(.DEPTH_WORDS(64), .INIT_MODE(0)) dut_s (
    .clk(clk), .a_rst(a_rst), .d_mem_assert(d_mem_assert), .d_mem_cmd(d_mem_cmd),
    .d_mem_addr(d_mem_addr), .d_mem_be(d_mem_be), .d_mem_data_out(d_mem_data_out),
    .d_mem_data_in(s_data_in), .d_mem_rdy(s_rdy), .d_mem_err(s_err),
    .cfg_wait(cfg_wait), .init_busy(s_init_busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request, then scramble the bus while the responder is busy.
  task automatic do_req(input logic cmd, input logic [15:0] addr, input logic [1:0] be,
                        input logic [15:0] data, input logic [3:0] wt, output int n);
    d_mem_cmd      = cmd;
    d_mem_addr     = addr;
    d_mem_be       = be;
    d_mem_data_out = data;
    cfg_wait       = wt;
    d_mem_assert   = 1'b1;
    step;
    d_mem_assert   = 1'b0;
    d_mem_addr     = 16'($urandom);
    d_mem_data_out = 16'($urandom);
    d_mem_be       = 2'($urandom);
    cfg_wait       = 4'($urandom);
    n = 0;
    while (d_mem_rdy !== 1'b1 && n < 64) begin
      step;
      n++;
    end
  endtask

  initial begin
    a_rst = 1'b0; d_mem_assert = 1'b0; d_mem_cmd = 1'b0; d_mem_addr = '0;
    d_mem_be = 2'b11; d_mem_data_out = '0; cfg_wait = '0;
    step;
    step;
    chk("rst_rdy", d_mem_rdy, 0);
    chk("rst_err", d_mem_err, 0);
    chk("rst_data", d_mem_data_in, 0);
    chk("rst_init_busy", init_busy, 1);

    // Init sweep, with a write request presented mid-sweep that must be ignored
    a_rst = 1'b1;
    repeat (100) step;
    d_mem_cmd = 1'b1; d_mem_addr = 16'hC000; d_mem_data_out = 16'hFFFF; d_mem_assert = 1'b1;
    repeat (100) step;
    d_mem_assert = 1'b0; d_mem_cmd = 1'b0;
    repeat (32567) step;
    chk("init_busy_last", init_busy, 1);
    chk("init_rdy_last", d_mem_rdy, 0);
    step;
    chk("init_done_busy", init_busy, 0);
    chk("init_done_rdy", d_mem_rdy, 1);

    do_req(1'b0, 16'hC000, 2'b11, 16'h0000, 4'd0, lat);
    chk("word_read_lat", lat, 1);
    chk("word_read_data", d_mem_data_in, 16'hC0C0);
    chk("word_read_err", d_mem_err, 0);

    do_req(1'b0, 16'hB001, 2'b01, 16'h0000, 4'd0, lat);
    chk("byte_read_data", d_mem_data_in, 16'h00B0);

    do_req(1'b1, 16'h00A3, 2'b01, 16'h1234, 4'd0, lat);
    chk("write_holds_data", d_mem_data_in, 16'h00B0);
    do_req(1'b0, 16'h00A2, 2'b11, 16'h0000, 4'd0, lat);
    chk("byte_wr_lane1", d_mem_data_in, 16'h0034);
    do_req(1'b1, 16'h00A2, 2'b10, 16'h5678, 4'd0, lat);
    do_req(1'b0, 16'h00A2, 2'b11, 16'h0000, 4'd0, lat);
    chk("byte_wr_lane0", d_mem_data_in, 16'h7834);

    do_req(1'b1, 16'h00A0, 2'b11, 16'hC000, 4'd3, lat);
    chk("wait3_lat", lat, 4);
    do_req(1'b0, 16'h00A0, 2'b11, 16'h0000, 4'd0, lat);
    chk("wait3_readback", d_mem_data_in, 16'hC000);

    do_req(1'b0, 16'hFFFF, 2'b11, 16'h0000, 4'd15, lat);
    chk("max_wait_lat", lat, 16);

    // Out-of-range on the 64-word instance
    do_req(1'b0, 16'h0080, 2'b11, 16'h0000, 4'd0, lat);
    chk("oor_read_err", s_err, 1);
    chk("oor_read_data", s_data_in, 0);
    do_req(1'b1, 16'h0080, 2'b11, 16'hFFFF, 4'd0, lat);
    chk("oor_write_err", s_err, 1);
    do_req(1'b0, 16'h0000, 2'b11, 16'h0000, 4'd0, lat);
    chk("oor_write_dropped", s_data_in, 0);
    chk("inrange_err_clear", s_err, 0);
    do_req(1'b0, 16'h007E, 2'b11, 16'h0000, 4'd0, lat);
    chk("last_word_err", s_err, 0);

    // Back-to-back reads with cfg_wait = 1
    do_req(1'b1, 16'h0010, 2'b11, 16'h1111, 4'd0, lat);
    do_req(1'b1, 16'h0012, 2'b11, 16'h2222, 4'd0, lat);
    do_req(1'b1, 16'h0014, 2'b11, 16'h3333, 4'd0, lat);
    d_mem_cmd = 1'b0; d_mem_be = 2'b11; cfg_wait = 4'd1;
    d_mem_addr = 16'h0010; d_mem_assert = 1'b1;
    step;
    chk("b2b_busy0", d_mem_rdy, 0);
    step;
    step;
    chk("b2b_done0", d_mem_rdy, 1);
    chk("b2b_data0", d_mem_data_in, 16'h1111);
    d_mem_addr = 16'h0012;
    step;
    chk("b2b_busy1", d_mem_rdy, 0);
    step;
    step;
    chk("b2b_done1", d_mem_rdy, 1);
    chk("b2b_data1", d_mem_data_in, 16'h2222);
    d_mem_addr = 16'h0014;
    step;
    chk("b2b_busy2", d_mem_rdy, 0);
    step;
    step;
    chk("b2b_done2", d_mem_rdy, 1);
    chk("b2b_data2", d_mem_data_in, 16'h3333);
    d_mem_assert = 1'b0;
    step;
    chk("b2b_idle_rdy", d_mem_rdy, 1);

    // Reset while a write is still waiting
    d_mem_cmd = 1'b1; d_mem_addr = 16'h0020; d_mem_be = 2'b11;
    d_mem_data_out = 16'hBEEF; cfg_wait = 4'd5; d_mem_assert = 1'b1;
    step;
    d_mem_assert = 1'b0;
    step;
    step;
    a_rst = 1'b0;
    step;
    chk("midrst_rdy", d_mem_rdy, 0);
    chk("midrst_err", d_mem_err, 0);
    chk("midrst_data", d_mem_data_in, 0);
    chk("midrst_init_busy", init_busy, 1);
    chk("midrst_s_init_busy", s_init_busy, 1);
    a_rst = 1'b1; d_mem_cmd = 1'b0;
    lat = 0;
    while (d_mem_rdy !== 1'b1 && lat < 40000) begin
      step;
      lat++;
    end
    chk("reinit_len", lat, 32768);
    do_req(1'b0, 16'h0020, 2'b11, 16'h0000, 4'd0, lat);
    chk("dropped_write_big", d_mem_data_in, 16'h0000);
    chk("dropped_write_small", s_data_in, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
